// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_rom_arbiter_if : requester, shared-ROM and return bus     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
);
  logic                    frame_start;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr_in;
  logic [N_REQ-1:0]        gnt;
  logic                    rom_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [DATA_W-1:0]       rd_data;
  logic [N_REQ-1:0]        rd_valid;

  // Sprite units plus ROM, as seen from outside the arbiter
  modport master (
    output frame_start, req, addr_in, rom_data,
    input  gnt, rom_en, rom_addr, rd_data, rd_valid
  );

  modport slave (
    input  frame_start, req, addr_in, rom_data,
    output gnt, rom_en, rom_addr, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_rom_arbiter : round-robin share of one sync sprite ROM    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  start;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [N_REQ-1:0]  gnt;
  logic [ADDR_W-1:0] win_addr;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
  logic [DATA_W-1:0] rd_data_q;
  logic [N_REQ-1:0]  rd_valid_q;

  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    idx      = '0;
    win      = '0;
    win_addr = '0;
    ptr_d    = ptr_q;
    // frame_start restarts the search at requester 0 for repeatable fetch order
    start    = bus.frame_start ? '0 : ptr_q;

    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(start) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (!reset_n) begin
      found = 1'b0;
    end

    if (found) begin
      gnt[win] = 1'b1;
    end

    for (int k = 0; k < N_REQ; k++) begin
      if (win == PTR_W'(k)) begin
        win_addr = bus.addr_in[k*ADDR_W +: ADDR_W];
      end
    end

    if (found) begin
      ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + PTR_W'(1);
    end else if (bus.frame_start) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      for (int s = 0; s <= ROM_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      rom_en_q <= found;
      if (found) begin
        rom_addr_q <= win_addr;
      end

      // Tag stage ROM_LAT lines up with the cycle rom_data is valid
      tag_q[0] <= gnt;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end

      rd_valid_q <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) begin
        rd_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sprite_rom_arbiter : self-checking bench with reference model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 14;
  localparam int DW  = 12;
  localparam int LAT = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sprite_rom_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ROM_LAT(LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[13:12], a[9:0]} ^ 12'hA5C;
  endfunction

  // One-cycle synchronous ROM
  always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

  // Reference model: grant by search order, results appear LAT+2 cycles later
  typedef struct {
    int            due;
    logic [N-1:0]  owner;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend[$];
  int            cyc        = 0;
  int            m_ptr      = 0;
  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_rd_valid = '0;
  logic [DW-1:0] e_rd_data  = '0;
  logic          e_rom_en   = 1'b0;
  logic [AW-1:0] e_rom_addr = '0;

  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input int from);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      if (g == '0 && r[(from + k) % N]) g[(from + k) % N] = 1'b1;
    end
    return g;
  endfunction

  always_comb e_gnt = reset_n ? pick(bus.req, bus.frame_start ? 0 : m_ptr) : '0;

  always @(posedge clk) begin
    logic [N-1:0] g;
    int           w;
    pend_t        p;
    g = e_gnt;
    w = 0;
    for (int i = 0; i < N; i++) if (g[i]) w = i;
    if (!reset_n) begin
      m_ptr = 0;
      pend.delete();
      e_rom_en   = 1'b0;
      e_rom_addr = '0;
      e_rd_valid = '0;
      e_rd_data  = '0;
    end else begin
      e_rd_valid = '0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        e_rd_valid = pend[0].owner;
        e_rd_data  = rom_word(pend[0].addr);
        void'(pend.pop_front());
      end
      if (g != '0) begin
        m_ptr      = (w + 1) % N;
        e_rom_en   = 1'b1;
        e_rom_addr = bus.addr_in[w*AW +: AW];
        p.due   = cyc + LAT + 2;
        p.owner = g;
        p.addr  = bus.addr_in[w*AW +: AW];
        pend.push_back(p);
      end else begin
        e_rom_en = 1'b0;
        if (bus.frame_start) m_ptr = 0;
      end
    end
    cyc++;
  end

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    bus.frame_start = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic randomize_addrs();
    for (int i = 0; i < N; i++) bus.addr_in[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '1;
    bus.frame_start = 1'b0;
    randomize_addrs();
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
      checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b exp 0", bus.rom_en); end
      checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL reset_rd_valid got %b exp 0000", bus.rd_valid); end
      checks++; if (bus.rom_addr !== 14'h0) begin errors++; $display("FAIL reset_rom_addr got %h exp 0", bus.rom_addr); end
      checks++; if (bus.rd_data !== 12'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
    end
    reset_n = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_release_gnt got %b exp 0001", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [8];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset(2);
    randomize_addrs();
    bus.req = '1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (bus.gnt !== seq[k]) begin errors++; $display("FAIL rr_gnt step %0d got %b exp %b", k, bus.gnt, seq[k]); end
      if (k >= 1) begin
        checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL rr_rom_en step %0d got %b exp 1", k, bus.rom_en); end
        checks++; if (bus.rom_addr !== e_rom_addr) begin errors++; $display("FAIL rr_rom_addr step %0d got %h exp %h", k, bus.rom_addr, e_rom_addr); end
      end
      if (k >= 3) begin
        checks++; if (bus.rd_valid !== seq[k-3]) begin errors++; $display("FAIL rr_rd_valid step %0d got %b exp %b", k, bus.rd_valid, seq[k-3]); end
      end
    end
    @(negedge clk);
    bus.req = '0;
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL rr_rom_en_last got %b exp 1", bus.rom_en); end
  endtask

  task automatic test_latency();
    apply_reset(2);
    randomize_addrs();
    bus.addr_in[2*AW +: AW] = 14'h0123;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL lat_gnt got %b exp 0100", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL lat_rom_en got %b exp 1", bus.rom_en); end
    checks++; if (bus.rom_addr !== 14'h0123) begin errors++; $display("FAIL lat_rom_addr got %h exp 0123", bus.rom_addr); end
    checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL lat_rd_valid_t1 got %b exp 0000", bus.rd_valid); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL lat_rd_valid_t2 got %b exp 0000", bus.rd_valid); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 4'b0100) begin errors++; $display("FAIL lat_rd_valid_t3 got %b exp 0100", bus.rd_valid); end
    checks++; if (bus.rd_data !== rom_word(14'h0123)) begin errors++; $display("FAIL lat_rd_data got %h exp %h", bus.rd_data, rom_word(14'h0123)); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL lat_rd_valid_t4 got %b exp 0000", bus.rd_valid); end
    checks++; if (bus.rd_data !== rom_word(14'h0123)) begin errors++; $display("FAIL lat_rd_data_hold got %h exp %h", bus.rd_data, rom_word(14'h0123)); end
  endtask

  task automatic test_frame_start();
    apply_reset(2);
    randomize_addrs();
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL fs_setup_gnt got %b exp 0100", bus.gnt); end
    @(negedge clk);
    bus.req = 4'b1001;
    bus.frame_start = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL fs_gnt got %b exp 0001", bus.gnt); end
    @(negedge clk);
    bus.frame_start = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL fs_after_gnt got %b exp 1000", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
  endtask

  task automatic test_reset_midflight();
    apply_reset(2);
    randomize_addrs();
    bus.req = 4'b0010;
    #1;
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b exp 0010", bus.gnt); end
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '1;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_in_reset got %b exp 0000", bus.gnt); end
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL mid_rom_en_pre got %b exp 1", bus.rom_en); end
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = '0;
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL mid_rom_en got %b exp 0", bus.rom_en); end
    checks++; if (bus.rom_addr !== 14'h0) begin errors++; $display("FAIL mid_rom_addr got %h exp 0", bus.rom_addr); end
    checks++; if (bus.rd_data !== 12'h0) begin errors++; $display("FAIL mid_rd_data got %h exp 0", bus.rd_data); end
    checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL mid_rd_valid_t2 got %b exp 0000", bus.rd_valid); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL mid_rd_valid_late got %b exp 0000", bus.rd_valid); end
    end
  endtask

  task automatic test_starvation();
    int           waitc [N];
    int           ngnt  [N];
    int           nret  [N];
    logic [N-1:0] last_g;
    logic [N-1:0] hold;
    apply_reset(2);
    for (int i = 0; i < N; i++) begin waitc[i] = 0; ngnt[i] = 0; nret[i] = 0; end
    last_g = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++; if (bus.rd_valid !== e_rd_valid) begin errors++; $display("FAIL stv_rd_valid cyc %0d got %b exp %b", c, bus.rd_valid, e_rd_valid); end
      checks++; if (bus.rd_data !== e_rd_data) begin errors++; $display("FAIL stv_rd_data cyc %0d got %h exp %h", c, bus.rd_data, e_rd_data); end
      checks++; if (bus.rom_en !== e_rom_en || bus.rom_addr !== e_rom_addr) begin errors++; $display("FAIL stv_rom cyc %0d got %b/%h exp %b/%h", c, bus.rom_en, bus.rom_addr, e_rom_en, e_rom_addr); end
      for (int i = 0; i < N; i++) if (bus.rd_valid[i]) nret[i]++;
      hold = bus.req & ~last_g;
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          bus.req[i] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          bus.addr_in[i*AW +: AW] = AW'($urandom);
        end
      end
      #1;
      checks++; if (bus.gnt !== e_gnt) begin errors++; $display("FAIL stv_gnt cyc %0d got %b exp %b", c, bus.gnt, e_gnt); end
      last_g = bus.gnt;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          ngnt[i]++;
          checks++; if (waitc[i] >= N) begin errors++; $display("FAIL stv_wait req %0d waited %0d limit %0d", i, waitc[i], N - 1); end
          waitc[i] = 0;
        end else if (bus.req[i]) begin
          waitc[i]++;
        end
      end
    end
    @(negedge clk);
    bus.req = '0;
    for (int i = 0; i < N; i++) if (bus.rd_valid[i]) nret[i]++;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.rd_valid[i]) nret[i]++;
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (nret[i] !== ngnt[i]) begin errors++; $display("FAIL stv_count req %0d returns %0d grants %0d", i, nret[i], ngnt[i]); end
      checks++; if (waitc[i] >= N) begin errors++; $display("FAIL stv_final_wait req %0d waited %0d limit %0d", i, waitc[i], N - 1); end
    end
  endtask

  task automatic test_random_frames();
    logic [N-1:0] last_g;
    logic [N-1:0] hold;
    apply_reset(2);
    last_g = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (bus.rd_valid !== e_rd_valid) begin errors++; $display("FAIL rnd_rd_valid cyc %0d got %b exp %b", c, bus.rd_valid, e_rd_valid); end
      checks++; if (bus.rd_data !== e_rd_data) begin errors++; $display("FAIL rnd_rd_data cyc %0d got %h exp %h", c, bus.rd_data, e_rd_data); end
      checks++; if (bus.rom_en !== e_rom_en || bus.rom_addr !== e_rom_addr) begin errors++; $display("FAIL rnd_rom cyc %0d got %b/%h exp %b/%h", c, bus.rom_en, bus.rom_addr, e_rom_en, e_rom_addr); end
      hold = bus.req & ~last_g;
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          bus.req[i] = 1'($urandom_range(0, 1));
          bus.addr_in[i*AW +: AW] = AW'($urandom);
        end
      end
      bus.frame_start = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (bus.gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", c, bus.gnt, e_gnt); end
      last_g = bus.gnt;
    end
    @(negedge clk);
    bus.req = '0;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.req         = '0;
    bus.frame_start = 1'b0;
    bus.addr_in     = '0;
    test_reset();
    test_round_robin();
    test_latency();
    test_frame_start();
    test_reset_midflight();
    test_starvation();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
